// File: rtl/execute_unit_m.sv
// execute_unit_m -- RV32IM execute stage with valid/ready handshakes on both
// sides and a pipeline flush.
//
// Ports:
//   i_clk, i_reset_n    clock, asynchronous active-low reset
//   i_flush             drop the in-flight mul/div and the output register
//   i_valid / o_ready   upstream handshake
//   i_pc, i_control_signal, i_rs1, i_rs2, i_imm   op and operands
//   o_valid / i_ready   downstream handshake
//   o_control_signal    control of the op carried by the result
//   o_rd_output         rd value, or memory address for mem ops
//   o_pc_ext, o_pc_load next-PC target and redirect flag
//   o_state             FSM state (EXU_IDLE / EXU_MUL / EXU_DIV)
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high on that side. o_ready never depends on i_valid. The output register is
// held unchanged while o_valid && !i_ready.

package execute_unit_pkg;
    typedef struct packed {
        logic       alu_imm;
        logic       alu_reg;
        logic       cond_branch;
        logic       uncond_branch;
        logic       load_upper_imm;
        logic       mem;
        logic       muldiv;
        logic       iop;
        logic [2:0] fcs_opcode;
    } control_s;

    typedef enum logic [1:0] {
        EXU_IDLE = 2'd0,
        EXU_MUL  = 2'd1,
        EXU_DIV  = 2'd2
    } EXU_state_t;
endpackage

module execute_unit_m
    import execute_unit_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic            i_flush,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [XLEN-1:0] i_pc,
    input  control_s        i_control_signal,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic [XLEN-1:0] i_imm,
    output logic            o_valid,
    input  logic            i_ready,
    output control_s        o_control_signal,
    output logic [XLEN-1:0] o_rd_output,
    output logic [XLEN-1:0] o_pc_ext,
    output logic            o_pc_load,
    output EXU_state_t      o_state
);
    localparam int SHW   = $clog2(XLEN);
    localparam int CNT_W = $clog2(XLEN + MUL_STAGES + 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    EXU_state_t       state_q, state_d;
    logic             valid_q, valid_d;
    logic [XLEN-1:0]  rd_q, rd_d, pc_ext_q, pc_ext_d;
    logic             pc_load_q, pc_load_d;
    control_s         ctrl_q, ctrl_d, op_ctrl_q, op_ctrl_d;
    logic [XLEN-1:0]  op_pc_q, op_pc_d;
    // opa/opb hold the multiplier operands, or dividend-shift/divisor magnitude
    logic [XLEN-1:0]  opa_q, opa_d, opb_q, opb_d, rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             quo_neg_q, quo_neg_d, rem_neg_q, rem_neg_d;

    // ---------------- single-cycle datapath (from the inputs) ----------------
    logic [XLEN-1:0] op_b, alu_res, pc_plus4, pc_plus_imm, rs1_plus_imm;
    logic [SHW-1:0]  shamt;
    logic            br_taken;
    logic [XLEN-1:0] sc_rd, sc_pc_ext;
    logic            sc_pc_load;
    logic            div_signed, a_neg, b_neg, div_zero, div_special;
    logic [XLEN-1:0] a_mag, b_mag, special_res;

    always_comb begin
        op_b         = i_control_signal.alu_imm ? i_imm : i_rs2;
        shamt        = op_b[SHW-1:0];
        pc_plus4     = i_pc + XLEN'(4);
        pc_plus_imm  = i_pc + i_imm;
        rs1_plus_imm = i_rs1 + i_imm;

        case (i_control_signal.fcs_opcode)
            3'b000:  alu_res = i_control_signal.iop ? i_rs1 - op_b : i_rs1 + op_b;
            3'b001:  alu_res = i_rs1 << shamt;
            3'b010:  alu_res = XLEN'($signed(i_rs1) < $signed(op_b));
            3'b011:  alu_res = XLEN'(i_rs1 < op_b);
            3'b100:  alu_res = i_rs1 ^ op_b;
            3'b101:  alu_res = i_control_signal.iop ? $unsigned($signed(i_rs1) >>> shamt)
                                                    : i_rs1 >> shamt;
            3'b110:  alu_res = i_rs1 | op_b;
            default: alu_res = i_rs1 & op_b;
        endcase

        case (i_control_signal.fcs_opcode)
            3'b000:  br_taken = (i_rs1 == i_rs2);
            3'b001:  br_taken = (i_rs1 != i_rs2);
            3'b100:  br_taken = ($signed(i_rs1) < $signed(i_rs2));
            3'b101:  br_taken = ($signed(i_rs1) >= $signed(i_rs2));
            3'b110:  br_taken = (i_rs1 < i_rs2);
            3'b111:  br_taken = (i_rs1 >= i_rs2);
            default: br_taken = 1'b0;
        endcase

        // Divide set-up: odd fcs codes are the unsigned forms, fcs[1] selects REM.
        div_signed  = !i_control_signal.fcs_opcode[0];
        a_neg       = div_signed && i_rs1[XLEN-1];
        b_neg       = div_signed && i_rs2[XLEN-1];
        a_mag       = a_neg ? -i_rs1 : i_rs1;
        b_mag       = b_neg ? -i_rs2 : i_rs2;
        div_zero    = (i_rs2 == '0);
        div_special = div_zero || (div_signed && i_rs1 == MIN_NEG && i_rs2 == '1);
        if (i_control_signal.fcs_opcode[1])
            special_res = div_zero ? i_rs1 : '0;
        else
            special_res = div_zero ? '1 : i_rs1;

        sc_rd      = '0;
        sc_pc_ext  = pc_plus4;
        sc_pc_load = 1'b0;
        if (i_control_signal.muldiv) begin
            sc_rd = special_res;  // only used for divide special cases
        end else if (i_control_signal.alu_imm || i_control_signal.alu_reg) begin
            sc_rd = alu_res;
        end else if (i_control_signal.cond_branch) begin
            sc_pc_load = br_taken;
            sc_pc_ext  = br_taken ? pc_plus_imm : pc_plus4;
        end else if (i_control_signal.uncond_branch) begin
            sc_rd      = pc_plus4;
            sc_pc_load = 1'b1;
            sc_pc_ext  = (i_control_signal.fcs_opcode == 3'b011) ?
                         {rs1_plus_imm[XLEN-1:1], 1'b0} : pc_plus_imm;
        end else if (i_control_signal.load_upper_imm) begin
            sc_rd = i_control_signal.iop ? i_imm : pc_plus_imm;
        end else if (i_control_signal.mem) begin
            sc_rd = rs1_plus_imm;
        end
    end

    // ---------------- multi-cycle datapath (from latched operands) -----------
    logic            mul_sa, mul_sb;
    logic [2*XLEN-1:0] mul_prod;
    logic [XLEN-1:0] mul_res, div_res;
    logic [XLEN:0]   div_shift;
    logic            div_ge;

    always_comb begin
        // MULH is s*s, MULHSU s*u; sign-extend to 2*XLEN so an unsigned multiply
        // yields the correct two's-complement product.
        mul_sa   = (op_ctrl_q.fcs_opcode == 3'b001) || (op_ctrl_q.fcs_opcode == 3'b010);
        mul_sb   = (op_ctrl_q.fcs_opcode == 3'b001);
        mul_prod = {{XLEN{mul_sa && opa_q[XLEN-1]}}, opa_q} *
                   {{XLEN{mul_sb && opb_q[XLEN-1]}}, opb_q};
        mul_res  = (op_ctrl_q.fcs_opcode[1:0] == 2'b00) ? mul_prod[XLEN-1:0]
                                                         : mul_prod[2*XLEN-1:XLEN];

        // One restoring step: shift the next dividend bit into the remainder.
        div_shift = {rem_q, opa_q[XLEN-1]};
        div_ge    = (div_shift >= {1'b0, opb_q});
        if (op_ctrl_q.fcs_opcode[1])
            div_res = rem_neg_q ? -rem_q : rem_q;
        else
            div_res = quo_neg_q ? -opa_q : opa_q;
    end

    // ---------------- control FSM --------------------------------------------
    logic out_free, accept;

    always_comb begin
        out_free = !valid_q || i_ready;
        o_ready  = (state_q == EXU_IDLE) && out_free && !i_flush;
        accept   = i_valid && o_ready;

        state_d   = state_q;
        valid_d   = valid_q && !i_ready;
        rd_d      = rd_q;
        pc_ext_d  = pc_ext_q;
        pc_load_d = pc_load_q;
        ctrl_d    = ctrl_q;
        op_ctrl_d = op_ctrl_q;
        op_pc_d   = op_pc_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;

        if (i_flush) begin
            valid_d = 1'b0;
            state_d = EXU_IDLE;
        end else begin
            case (state_q)
                EXU_IDLE: if (accept) begin
                    op_ctrl_d = i_control_signal;
                    op_pc_d   = i_pc;
                    cnt_d     = '0;
                    if (i_control_signal.muldiv && !i_control_signal.fcs_opcode[2]) begin
                        state_d = EXU_MUL;
                        opa_d   = i_rs1;
                        opb_d   = i_rs2;
                    end else if (i_control_signal.muldiv && !div_special) begin
                        state_d   = EXU_DIV;
                        opa_d     = a_mag;
                        opb_d     = b_mag;
                        rem_d     = '0;
                        quo_neg_d = a_neg ^ b_neg;
                        rem_neg_d = a_neg;
                    end else begin
                        valid_d   = 1'b1;
                        rd_d      = sc_rd;
                        pc_ext_d  = sc_pc_ext;
                        pc_load_d = sc_pc_load;
                        ctrl_d    = i_control_signal;
                    end
                end
                EXU_MUL: begin
                    if (cnt_q == CNT_W'(MUL_STAGES - 1)) begin
                        if (out_free) begin
                            state_d   = EXU_IDLE;
                            valid_d   = 1'b1;
                            rd_d      = mul_res;
                            pc_ext_d  = op_pc_q + XLEN'(4);
                            pc_load_d = 1'b0;
                            ctrl_d    = op_ctrl_q;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                EXU_DIV: begin
                    if (cnt_q == CNT_W'(XLEN)) begin
                        if (out_free) begin
                            state_d   = EXU_IDLE;
                            valid_d   = 1'b1;
                            rd_d      = div_res;
                            pc_ext_d  = op_pc_q + XLEN'(4);
                            pc_load_d = 1'b0;
                            ctrl_d    = op_ctrl_q;
                        end
                    end else begin
                        rem_d = div_ge ? XLEN'(div_shift - {1'b0, opb_q}) : div_shift[XLEN-1:0];
                        opa_d = {opa_q[XLEN-2:0], div_ge};
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = EXU_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= EXU_IDLE;
            valid_q   <= 1'b0;
            rd_q      <= '0;
            pc_ext_q  <= '0;
            pc_load_q <= 1'b0;
            ctrl_q    <= '0;
            op_ctrl_q <= '0;
            op_pc_q   <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            rd_q      <= rd_d;
            pc_ext_q  <= pc_ext_d;
            pc_load_q <= pc_load_d;
            ctrl_q    <= ctrl_d;
            op_ctrl_q <= op_ctrl_d;
            op_pc_q   <= op_pc_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
        end
    end

    assign o_valid          = valid_q;
    assign o_rd_output      = rd_q;
    assign o_pc_ext         = pc_ext_q;
    assign o_pc_load        = pc_load_q;
    assign o_control_signal = ctrl_q;
    assign o_state          = state_q;
endmodule

// File: tb/tb_execute_unit_m.sv
// tb_execute_unit_m -- directed, table-driven bench for execute_unit_m
// (XLEN=32, MUL_STAGES=2) plus hand-written handshake/flush/reset sequences.
module tb_execute_unit_m;
    import execute_unit_pkg::*;

    localparam int XLEN = 32;
    localparam int MS   = 2;

    // class one-hots: {muldiv, alu_imm, alu_reg, cond, uncond, lui, mem}
    localparam logic [6:0] C_MD  = 7'b1000000;
    localparam logic [6:0] C_AI  = 7'b0100000;
    localparam logic [6:0] C_AR  = 7'b0010000;
    localparam logic [6:0] C_BR  = 7'b0001000;
    localparam logic [6:0] C_J   = 7'b0000100;
    localparam logic [6:0] C_LU  = 7'b0000010;
    localparam logic [6:0] C_MEM = 7'b0000001;

    logic            i_clk = 1'b0;
    logic            i_reset_n = 1'b0;
    logic            i_flush = 1'b0;
    logic            i_valid = 1'b0;
    logic            o_ready;
    logic [XLEN-1:0] i_pc = '0, i_rs1 = '0, i_rs2 = '0, i_imm = '0;
    control_s        i_control_signal = '0;
    logic            o_valid;
    logic            i_ready = 1'b1;
    control_s        o_control_signal;
    logic [XLEN-1:0] o_rd_output, o_pc_ext;
    logic            o_pc_load;
    EXU_state_t      o_state;

    execute_unit_m #(.XLEN(XLEN), .MUL_STAGES(MS)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_flush(i_flush),
        .i_valid(i_valid), .o_ready(o_ready), .i_pc(i_pc),
        .i_control_signal(i_control_signal), .i_rs1(i_rs1), .i_rs2(i_rs2),
        .i_imm(i_imm), .o_valid(o_valid), .i_ready(i_ready),
        .o_control_signal(o_control_signal), .o_rd_output(o_rd_output),
        .o_pc_ext(o_pc_ext), .o_pc_load(o_pc_load), .o_state(o_state)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        string      name;
        control_s   ctrl;
        logic [31:0] pc, rs1, rs2, imm, rd, pc_ext;
        logic       pc_load;
        logic       chk_rd;
        int         lat;
        EXU_state_t st;
    } vec_t;

    vec_t vecs[$];

    function automatic control_s mk(input logic [6:0] cls, input logic iop, input logic [2:0] fcs);
        control_s c;
        c.muldiv         = cls[6];
        c.alu_imm        = cls[5];
        c.alu_reg        = cls[4];
        c.cond_branch    = cls[3];
        c.uncond_branch  = cls[2];
        c.load_upper_imm = cls[1];
        c.mem            = cls[0];
        c.iop            = iop;
        c.fcs_opcode     = fcs;
        return c;
    endfunction

    task automatic add(input string nm, input logic [6:0] cls, input logic iop,
                       input logic [2:0] fcs, input logic [31:0] pc, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [31:0] imm, input logic [31:0] rd,
                       input logic [31:0] pc_ext, input logic pc_load, input logic chk_rd,
                       input int lat, input EXU_state_t st);
        vec_t v;
        v.name = nm; v.ctrl = mk(cls, iop, fcs);
        v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
        v.rd = rd; v.pc_ext = pc_ext; v.pc_load = pc_load; v.chk_rd = chk_rd;
        v.lat = lat; v.st = st;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input control_s c, input logic [31:0] pc, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [31:0] imm);
        i_valid = 1'b1; i_control_signal = c; i_pc = pc;
        i_rs1 = rs1; i_rs2 = rs2; i_imm = imm;
    endtask

    // Called #1 after a rising edge; returns #1 after the edge where o_valid is seen.
    task automatic run_vec(input vec_t v);
        int n;
        drive(v.ctrl, v.pc, v.rs1, v.rs2, v.imm);
        chk({v.name, "_ready"}, 32'(o_ready), 32'd1);
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        chk({v.name, "_state"}, 32'(o_state), 32'(v.st));
        n = 0;
        while (!o_valid && n < 100) begin
            @(posedge i_clk); #1;
            n++;
        end
        chk({v.name, "_latency"}, 32'(n), 32'(v.lat));
        if (v.chk_rd) chk({v.name, "_rd"}, o_rd_output, v.rd);
        chk({v.name, "_pc_ext"}, o_pc_ext, v.pc_ext);
        chk({v.name, "_pc_load"}, 32'(o_pc_load), 32'(v.pc_load));
        chk({v.name, "_ctrl"}, 32'(o_control_signal), 32'(v.ctrl));
    endtask

    initial begin
        bit seen;
        //  name       class       iop fcs     pc          rs1           rs2           imm           rd            pc_ext        ld  crd lat st
        add("addi",    C_AI,       0, 3'b000, 32'h0,      32'd5,        32'h0,        32'hFFFFFFF9, 32'hFFFFFFFE, 32'h4,        0, 1, 0,  EXU_IDLE);
        add("sra",     C_AR,       1, 3'b101, 32'h10,     32'h80000000, 32'd36,       32'h0,        32'hF8000000, 32'h14,       0, 1, 0,  EXU_IDLE);
        add("srl",     C_AR,       0, 3'b101, 32'h10,     32'h80000000, 32'd36,       32'h0,        32'h08000000, 32'h14,       0, 1, 0,  EXU_IDLE);
        add("sltu",    C_AR,       0, 3'b011, 32'h10,     32'd1,        32'hFFFFFFFF, 32'h0,        32'h1,        32'h14,       0, 1, 0,  EXU_IDLE);
        add("sub",     C_AR,       1, 3'b000, 32'h10,     32'd3,        32'd5,        32'h0,        32'hFFFFFFFE, 32'h14,       0, 1, 0,  EXU_IDLE);
        add("slt",     C_AR,       0, 3'b010, 32'h10,     32'hFFFFFFFF, 32'd1,        32'h0,        32'h1,        32'h14,       0, 1, 0,  EXU_IDLE);
        add("xori",    C_AI,       0, 3'b100, 32'h10,     32'hF0F0,     32'h0,        32'h0FF0,     32'hFF00,     32'h14,       0, 1, 0,  EXU_IDLE);
        add("slli",    C_AI,       0, 3'b001, 32'h10,     32'd1,        32'h0,        32'h1F,       32'h80000000, 32'h14,       0, 1, 0,  EXU_IDLE);
        add("andi",    C_AI,       0, 3'b111, 32'h10,     32'hABCD,     32'h0,        32'hFF,       32'hCD,       32'h14,       0, 1, 0,  EXU_IDLE);
        add("ori",     C_AI,       0, 3'b110, 32'h10,     32'hA0,       32'h0,        32'h0B,       32'hAB,       32'h14,       0, 1, 0,  EXU_IDLE);
        add("blt",     C_BR,       0, 3'b100, 32'h100,    32'hFFFFFFFF, 32'h0,        32'h20,       32'h0,        32'h120,      1, 0, 0,  EXU_IDLE);
        add("bgeu_nt", C_BR,       0, 3'b111, 32'h200,    32'd1,        32'd2,        32'h40,       32'h0,        32'h204,      0, 0, 0,  EXU_IDLE);
        add("beq",     C_BR,       0, 3'b000, 32'h300,    32'd7,        32'd7,        32'hFFFFFFF8, 32'h0,        32'h2F8,      1, 0, 0,  EXU_IDLE);
        add("bge_nt",  C_BR,       0, 3'b101, 32'h100,    32'hFFFFFFFF, 32'h0,        32'h20,       32'h0,        32'h104,      0, 0, 0,  EXU_IDLE);
        add("bltu",    C_BR,       0, 3'b110, 32'h500,    32'h0,        32'hFFFFFFFF, 32'h10,       32'h0,        32'h510,      1, 0, 0,  EXU_IDLE);
        add("br_bad",  C_BR,       0, 3'b010, 32'h600,    32'd1,        32'd1,        32'h10,       32'h0,        32'h604,      0, 0, 0,  EXU_IDLE);
        add("jal",     C_J,        0, 3'b010, 32'h1000,   32'h0,        32'h0,        32'h800,      32'h1004,     32'h1800,     1, 1, 0,  EXU_IDLE);
        add("jalr",    C_J,        0, 3'b011, 32'h40,     32'h203,      32'h0,        32'h0,        32'h44,       32'h202,      1, 1, 0,  EXU_IDLE);
        add("lui",     C_LU,       1, 3'b000, 32'h20,     32'h0,        32'h0,        32'h12345000, 32'h12345000, 32'h24,       0, 1, 0,  EXU_IDLE);
        add("auipc",   C_LU,       0, 3'b000, 32'h400,    32'h0,        32'h0,        32'h1000,     32'h1400,     32'h404,      0, 1, 0,  EXU_IDLE);
        add("mem",     C_MEM,      0, 3'b000, 32'h30,     32'h1000,     32'h0,        32'hFFFFFFFC, 32'hFFC,      32'h34,       0, 1, 0,  EXU_IDLE);
        add("nop",     7'b0,       0, 3'b000, 32'h50,     32'd9,        32'd9,        32'd9,        32'h0,        32'h54,       0, 1, 0,  EXU_IDLE);
        add("prio_alu",C_AR|C_BR,  0, 3'b000, 32'h60,     32'd1,        32'd1,        32'h0,        32'd2,        32'h64,       0, 1, 0,  EXU_IDLE);
        add("prio_md", C_MD|C_AR,  0, 3'b000, 32'h70,     32'd3,        32'd4,        32'h0,        32'd12,       32'h74,       0, 1, MS, EXU_MUL);
        add("mul",     C_MD,       0, 3'b000, 32'h70,     32'd6,        32'd7,        32'h0,        32'd42,       32'h74,       0, 1, MS, EXU_MUL);
        add("mul_neg", C_MD,       0, 3'b000, 32'h70,     32'hFFFFFFFD, 32'd5,        32'h0,        32'hFFFFFFF1, 32'h74,       0, 1, MS, EXU_MUL);
        add("mulh",    C_MD,       0, 3'b001, 32'h70,     32'h80000000, 32'h80000000, 32'h0,        32'h40000000, 32'h74,       0, 1, MS, EXU_MUL);
        add("mulhsu",  C_MD,       0, 3'b010, 32'h70,     32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'hFFFFFFFF, 32'h74,       0, 1, MS, EXU_MUL);
        add("mulhu",   C_MD,       0, 3'b011, 32'h70,     32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'hFFFFFFFE, 32'h74,       0, 1, MS, EXU_MUL);
        add("div",     C_MD,       0, 3'b100, 32'h80,     32'hFFFFFFF9, 32'd2,        32'h0,        32'hFFFFFFFD, 32'h84,       0, 1, 33, EXU_DIV);
        add("rem",     C_MD,       0, 3'b110, 32'h80,     32'hFFFFFFF9, 32'd2,        32'h0,        32'hFFFFFFFF, 32'h84,       0, 1, 33, EXU_DIV);
        add("rem_pn",  C_MD,       0, 3'b110, 32'h80,     32'd7,        32'hFFFFFFFE, 32'h0,        32'd1,        32'h84,       0, 1, 33, EXU_DIV);
        add("div_pn",  C_MD,       0, 3'b100, 32'h80,     32'd7,        32'hFFFFFFFE, 32'h0,        32'hFFFFFFFD, 32'h84,       0, 1, 33, EXU_DIV);
        add("remu",    C_MD,       0, 3'b111, 32'h80,     32'd100,      32'd7,        32'h0,        32'd2,        32'h84,       0, 1, 33, EXU_DIV);
        add("divu",    C_MD,       0, 3'b101, 32'h80,     32'hFFFFFFFF, 32'h10,       32'h0,        32'h0FFFFFFF, 32'h84,       0, 1, 33, EXU_DIV);
        add("divu_big",C_MD,       0, 3'b101, 32'h80,     32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h0,        32'h84,       0, 1, 33, EXU_DIV);
        add("divu_z",  C_MD,       0, 3'b101, 32'h80,     32'd100,      32'h0,        32'h0,        32'hFFFFFFFF, 32'h84,       0, 1, 0,  EXU_IDLE);
        add("remu_z",  C_MD,       0, 3'b111, 32'h80,     32'h55,       32'h0,        32'h0,        32'h55,       32'h84,       0, 1, 0,  EXU_IDLE);
        add("div_ovf", C_MD,       0, 3'b100, 32'h80,     32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 32'h84,       0, 1, 0,  EXU_IDLE);
        add("rem_ovf", C_MD,       0, 3'b110, 32'h80,     32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h0,        32'h84,       0, 1, 0,  EXU_IDLE);

        // ---- reset state ----
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_valid",   32'(o_valid), 32'd0);
        chk("rst_rd",      o_rd_output, 32'd0);
        chk("rst_pc_ext",  o_pc_ext, 32'd0);
        chk("rst_pc_load", 32'(o_pc_load), 32'd0);
        chk("rst_ctrl",    32'(o_control_signal), 32'd0);
        chk("rst_state",   32'(o_state), 32'(EXU_IDLE));
        i_reset_n = 1'b1;
        @(posedge i_clk); #1;
        chk("rst_ready", 32'(o_ready), 32'd1);

        // ---- vector table ----
        foreach (vecs[i]) run_vec(vecs[i]);

        // ---- back-to-back single-cycle ops ----
        drive(mk(C_AI, 0, 3'b000), 32'h0, 32'd0, 32'd0, 32'd1);
        @(posedge i_clk); #1;
        drive(mk(C_AI, 0, 3'b000), 32'h0, 32'd0, 32'd0, 32'd2);
        chk("b2b_1_valid", 32'(o_valid), 32'd1);
        chk("b2b_1_rd", o_rd_output, 32'd1);
        @(posedge i_clk); #1;
        drive(mk(C_AI, 0, 3'b000), 32'h0, 32'd0, 32'd0, 32'd3);
        chk("b2b_2_rd", o_rd_output, 32'd2);
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        chk("b2b_3_rd", o_rd_output, 32'd3);
        @(posedge i_clk); #1;
        chk("b2b_drain", 32'(o_valid), 32'd0);

        // ---- backpressure: hold i_ready low three cycles ----
        i_ready = 1'b0;
        drive(mk(C_AR, 0, 3'b000), 32'h0, 32'd1, 32'd1, 32'd0);
        @(posedge i_clk); #1;
        drive(mk(C_AR, 0, 3'b000), 32'h0, 32'd10, 32'd10, 32'd0);
        chk("bp_valid", 32'(o_valid), 32'd1);
        chk("bp_rd", o_rd_output, 32'd2);
        for (int k = 0; k < 3; k++) begin
            @(posedge i_clk); #1;
            chk("bp_hold_ready", 32'(o_ready), 32'd0);
            chk("bp_hold_valid", 32'(o_valid), 32'd1);
            chk("bp_hold_rd", o_rd_output, 32'd2);
        end
        i_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(o_ready), 32'd1);
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        chk("bp_next_valid", 32'(o_valid), 32'd1);
        chk("bp_next_rd", o_rd_output, 32'd20);
        @(posedge i_clk); #1;
        chk("bp_drain", 32'(o_valid), 32'd0);

        // ---- flush at divide iteration 10 ----
        drive(mk(C_MD, 0, 3'b100), 32'h0, 32'd100, 32'd3, 32'd0);
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        repeat (10) begin @(posedge i_clk); #1; end
        chk("fl_in_div", 32'(o_state), 32'(EXU_DIV));
        i_flush = 1'b1;
        drive(mk(C_AI, 0, 3'b000), 32'h0, 32'd0, 32'd0, 32'd7);
        #1;
        chk("fl_ready", 32'(o_ready), 32'd0);
        @(posedge i_clk); #1;
        i_flush = 1'b0;
        i_valid = 1'b0;
        chk("fl_valid", 32'(o_valid), 32'd0);
        chk("fl_state", 32'(o_state), 32'(EXU_IDLE));
        seen = 1'b0;
        repeat (40) begin
            @(posedge i_clk); #1;
            if (o_valid) seen = 1'b1;
        end
        chk("fl_no_result", 32'(seen), 32'd0);

        // ---- reset asserted mid-divide ----
        drive(mk(C_MD, 0, 3'b100), 32'h0, 32'd100, 32'd3, 32'd0);
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        repeat (5) begin @(posedge i_clk); #1; end
        chk("rd_in_div", 32'(o_state), 32'(EXU_DIV));
        i_reset_n = 1'b0;
        #1;
        chk("rd_valid", 32'(o_valid), 32'd0);
        chk("rd_state", 32'(o_state), 32'(EXU_IDLE));
        @(posedge i_clk); #1;
        i_reset_n = 1'b1;
        @(posedge i_clk); #1;
        chk("rd_ready", 32'(o_ready), 32'd1);
        run_vec(vecs[0]);
        @(posedge i_clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
